alu_sequencer: RTL and testbench

Multi-cycle front end for the 16-bit combinational ALU. It captures operands from the shared data bus and presents them to the ALU with select and carry-in. It drives the ALU enable, samples the ALU result, carry and zero outputs, and holds them in an accumulator and flag registers. On request it drives the accumulator back onto the shared bus through a tri-state output.

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_seq_flags.sv | 90 +++++++++
 rtl/alu_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_seq_pkg
// Purpose  : Shared state encoding, ALU op codes and carry-update mask for
//            the ALU sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXEC    = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_INC = 4'd6;
    localparam logic [3:0] OP_DEC = 4'd7;

    // One bit per op code: set where the ALU carry-out is architecturally meaningful.
    localparam logic [15:0] c_carry_ops = 16'b0000_0000_1100_0011;

    function automatic logic op_updates_carry(input logic [3:0] op);
        return c_carry_ops[op];
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_flags.sv
//------------------------------------------------------------------------------
// Module   : alu_seq_flags
// Purpose  : Carry/zero (and optional overflow, ALU_SEQ_OVERFLOW_EN) flag
//            registers with their update-select logic.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq_flags
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_capture,
    input  logic             i_clear_carry,
    input  logic [3:0]       i_op,
    input  logic             i_alu_carry_out,
    input  logic             i_alu_zero,
`ifdef ALU_SEQ_OVERFLOW_EN
    input  logic [WIDTH-1:0] i_opnd_a,
    input  logic [WIDTH-1:0] i_opnd_b,
    input  logic [WIDTH-1:0] i_result,
    output logic             o_overflow_flag,
`endif
    output logic             o_carry_flag,
    output logic             o_zero_flag
);

    logic r_carry;
    logic r_zero;

    // A capture that updates carry takes priority over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            if (i_capture && op_updates_carry(i_op)) begin
                r_carry <= i_alu_carry_out;
            end else if (i_clear_carry) begin
                r_carry <= 1'b0;
            end
            if (i_capture) begin
                r_zero <= i_alu_zero;
            end
        end
    end

    assign o_carry_flag = r_carry;
    assign o_zero_flag  = r_zero;

`ifdef ALU_SEQ_OVERFLOW_EN
    logic r_overflow;
    logic w_overflow;
    logic w_sa;
    logic w_sb;
    logic w_sr;

    assign w_sa = i_opnd_a[WIDTH-1];
    assign w_sb = i_opnd_b[WIDTH-1];
    assign w_sr = i_result[WIDTH-1];

    // INC/DEC behave as ADD/SUB with a positive unit B operand.
    always_comb begin
        w_overflow = 1'b0;
        case (i_op)
            OP_ADD:  w_overflow = (w_sa == w_sb) && (w_sr != w_sa);
            OP_INC:  w_overflow = !w_sa && w_sr;
            OP_SUB:  w_overflow = (w_sa != w_sb) && (w_sr != w_sa);
            OP_DEC:  w_overflow = w_sa && !w_sr;
            default: w_overflow = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (i_capture) begin
            r_overflow <= w_overflow;
        end
    end

    assign o_overflow_flag = r_overflow;
`endif

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
//------------------------------------------------------------------------------
// Module   : alu_sequencer
// Purpose  : Multi-cycle front end for a 16-bit combinational ALU: operand
//            capture, enable sequencing, accumulator/flags, tri-state readback.
//            Optional overflow flag: ALU_SEQ_OVERFLOW_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_sequencer #(
    parameter int          WIDTH  = 16,
    parameter int unsigned OP_MAX = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             exec,
    input  logic [3:0]       op,
    input  logic             out_en,
    input  logic             clear_carry,
    output logic             busy,
    output logic             done,
    output logic             op_error,
    output logic [WIDTH-1:0] acc,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic [WIDTH-1:0] alu_in_1,
    output logic [WIDTH-1:0] alu_in_2,
    output logic [3:0]       alu_select,
    output logic             alu_carry_in,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             alu_carry_out,
`ifdef ALU_SEQ_OVERFLOW_EN
    output logic             overflow_flag,
`endif
    input  logic             alu_zero
);

    import alu_seq_pkg::*;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic             r_op_error;
    logic             r_alu_enable;
    logic             w_alu_enable_next;
    logic             w_op_invalid;
    logic             w_idle;

    assign w_idle       = (r_state == IDLE);
    assign w_op_invalid = (32'(op) > OP_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (exec) w_next_state = w_op_invalid ? DONE : EXEC;
            EXEC:    w_next_state = CAPTURE;
            CAPTURE: w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy              = (r_state != IDLE);
        done              = (r_state == DONE);
        w_alu_enable_next = (w_next_state == EXEC) || (w_next_state == CAPTURE);
    end

    // Operands and op code only move in IDLE, so the ALU sees stable inputs
    // across the whole EXEC/CAPTURE window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_acc        <= '0;
            r_op_error   <= 1'b0;
            r_alu_enable <= 1'b0;
        end else begin
            r_alu_enable <= w_alu_enable_next;
            if (w_idle) begin
                if (load_a) r_a <= bus_in;
                if (load_b) r_b <= bus_in;
                if (exec) begin
                    r_op       <= op;
                    r_op_error <= w_op_invalid;
                end
            end
            if (r_state == CAPTURE) begin
                r_acc <= alu_data;
            end
        end
    end

    alu_seq_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .clk             (clk),
        .rst             (reset),
        .i_capture       (r_state == CAPTURE),
        .i_clear_carry   (clear_carry),
        .i_op            (r_op),
        .i_alu_carry_out (alu_carry_out),
        .i_alu_zero      (alu_zero),
`ifdef ALU_SEQ_OVERFLOW_EN
        .i_opnd_a        (r_a),
        .i_opnd_b        (r_b),
        .i_result        (alu_data),
        .o_overflow_flag (overflow_flag),
`endif
        .o_carry_flag    (carry_flag),
        .o_zero_flag     (zero_flag)
    );

    assign acc          = r_acc;
    assign op_error     = r_op_error;
    assign alu_in_1     = r_a;
    assign alu_in_2     = r_b;
    assign alu_select   = r_op;
    assign alu_carry_in = carry_flag;
    assign alu_enable   = r_alu_enable;

    // The bus is released while reset is held, regardless of out_en.
    assign bus_out = (out_en && !reset) ? r_acc : {WIDTH{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer with an environment ALU and
//            a scoreboard of expected results per exec.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_alu_sequencer;

    localparam int WIDTH  = 16;
    localparam int OP_MAX = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out;
    logic             load_a, load_b, exec, out_en, clear_carry;
    logic [3:0]       op;
    logic             busy, done, op_error, carry_flag, zero_flag;
    logic [WIDTH-1:0] acc, alu_in_1, alu_in_2, alu_data;
    logic [3:0]       alu_select;
    logic             alu_carry_in, alu_enable, alu_carry_out, alu_zero;
`ifdef ALU_SEQ_OVERFLOW_EN
    logic             overflow_flag;
`endif

    alu_sequencer #(.WIDTH(WIDTH), .OP_MAX(OP_MAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_in        (bus_in),
        .bus_out       (bus_out),
        .load_a        (load_a),
        .load_b        (load_b),
        .exec          (exec),
        .op            (op),
        .out_en        (out_en),
        .clear_carry   (clear_carry),
        .busy          (busy),
        .done          (done),
        .op_error      (op_error),
        .acc           (acc),
        .carry_flag    (carry_flag),
        .zero_flag     (zero_flag),
        .alu_in_1      (alu_in_1),
        .alu_in_2      (alu_in_2),
        .alu_select    (alu_select),
        .alu_carry_in  (alu_carry_in),
        .alu_enable    (alu_enable),
        .alu_data      (alu_data),
        .alu_carry_out (alu_carry_out),
`ifdef ALU_SEQ_OVERFLOW_EN
        .overflow_flag (overflow_flag),
`endif
        .alu_zero      (alu_zero)
    );

    always #5 clk = ~clk;

    // Environment ALU: {carry, result}. Logic ops return ~cin as carry so any
    // wrongful carry update becomes visible.
    function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s, input logic cin);
        case (s)
            4'd0:    return {1'b0, a} + {1'b0, b} + 17'(cin);
            4'd1:    return {1'b0, a} - {1'b0, b} - 17'(cin);
            4'd2:    return {~cin, a & b};
            4'd3:    return {~cin, a | b};
            4'd4:    return {~cin, a ^ b};
            4'd5:    return {~cin, ~a};
            4'd6:    return {1'b0, a} + 17'd1;
            4'd7:    return {1'b0, a} - 17'd1;
            default: return {1'b1, 16'hDEAD};
        endcase
    endfunction

    // Result is only meaningful after an enabled edge; otherwise junk.
    always @(posedge clk) begin
        if (alu_enable) {alu_carry_out, alu_data} <= alu_f(alu_in_1, alu_in_2, alu_select, alu_carry_in);
        else            {alu_carry_out, alu_data} <= 17'($urandom);
    end
    assign alu_zero = (alu_data == '0);

    int cyc = 0;
    int en_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (alu_enable) en_cnt++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] acc;
        logic        carry;
        logic        zero;
        logic        err;
        logic        ovf;
        int          cyc;
    } exp_t;
    exp_t q[$];

    logic [15:0] m_a, m_b, m_acc;
    logic        m_carry, m_zero, m_err, m_ovf;

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1'b1, 1'b0);
            end else begin
                e = q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("acc", acc, e.acc);
                check("carry_flag", carry_flag, e.carry);
                check("zero_flag", zero_flag, e.zero);
                check("op_error", op_error, e.err);
                check("busy_at_done", busy, 1'b1);
`ifdef ALU_SEQ_OVERFLOW_EN
                check("overflow_flag", overflow_flag, e.ovf);
`endif
            end
        end
    end

    task automatic model_reset();
        m_a = '0; m_b = '0; m_acc = '0;
        m_carry = 0; m_zero = 0; m_err = 0; m_ovf = 0;
    endtask

    task automatic load(input bit la, input bit lb, input logic [15:0] v);
        load_a = la; load_b = lb; bus_in = v;
        @(negedge clk);
        load_a = 0; load_b = 0;
        if (la) m_a = v;
        if (lb) m_b = v;
        check("operand_a", alu_in_1, m_a);
        check("operand_b", alu_in_2, m_b);
    endtask

    task automatic issue(input logic [3:0] o, input bit interfere);
        exp_t        e;
        logic [16:0] r;
        logic        sa, sb, sr;
        int          en0, t;
        bit          bad;
        bad   = int'(o) > OP_MAX;
        e.cyc = cyc + 1 + (bad ? 0 : 2);
        if (bad) begin
            m_err = 1;
        end else begin
            r  = alu_f(m_a, m_b, o, m_carry);
            sa = m_a[15]; sb = m_b[15]; sr = r[15];
            case (o)
                4'd0:    m_ovf = (sa == sb) && (sr != sa);
                4'd6:    m_ovf = !sa && sr;
                4'd1:    m_ovf = (sa != sb) && (sr != sa);
                4'd7:    m_ovf = sa && !sr;
                default: m_ovf = 0;
            endcase
            m_acc  = r[15:0];
            m_zero = (r[15:0] == 16'h0);
            if (o inside {4'd0, 4'd1, 4'd6, 4'd7}) m_carry = r[16];
            m_err = 0;
        end
        e.acc = m_acc; e.carry = m_carry; e.zero = m_zero; e.err = m_err; e.ovf = m_ovf;
        q.push_back(e);
        en0  = en_cnt;
        exec = 1; op = o;
        @(negedge clk);
        exec = 0;
        if (interfere) begin
            load_a = 1; bus_in = 16'hAAAA; exec = 1; op = 4'd1;
            @(negedge clk);
            load_a = 0; exec = 0;
        end
        t = 0;
        while (q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            check("done_timeout", 1'b0, 1'b1);
            q.delete();
        end
        @(negedge clk);
        check("alu_enable_cycles", 64'(en_cnt - en0), bad ? 64'd0 : 64'd2);
        if (interfere) check("a_reg_frozen", alu_in_1, m_a);
    endtask

    task automatic pulse_clear();
        clear_carry = 1;
        @(negedge clk);
        clear_carry = 0;
        m_carry = 0;
        check("carry_cleared", carry_flag, 1'b0);
    endtask

    task automatic bus_check();
        check("carry_in_follows", alu_carry_in, m_carry);
        out_en = 1; #1;
        check("bus_drive", bus_out, m_acc);
        out_en = 0; #1;
        check("bus_release", bus_out, {WIDTH{1'bz}});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_acc"}, acc, 16'h0);
        check({tag, "_carry"}, carry_flag, 1'b0);
        check({tag, "_zero"}, zero_flag, 1'b0);
        check({tag, "_op_error"}, op_error, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_alu_enable"}, alu_enable, 1'b0);
        check({tag, "_bus_out"}, bus_out, {WIDTH{1'bz}});
        check({tag, "_a"}, alu_in_1, 16'h0);
`ifdef ALU_SEQ_OVERFLOW_EN
        check({tag, "_overflow"}, overflow_flag, 1'b0);
`endif
    endtask

    initial begin
        reset = 1; bus_in = '0; load_a = 0; load_b = 0; exec = 0; op = '0;
        out_en = 1; clear_carry = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 0; out_en = 0;
        @(negedge clk);

        // Plain add
        load(1, 0, 16'h1234);
        load(0, 1, 16'h0F0F);
        issue(4'd0, 0);
        check("add_result", acc, 16'h2143);

        // Carry chain
        load(1, 0, 16'hFFFF);
        load(0, 1, 16'h0001);
        issue(4'd0, 0);
        check("chain_carry", carry_flag, 1'b1);
        load(1, 1, 16'h0000);
        issue(4'd0, 0);
        check("chain_result", acc, 16'h0001);

        // Logic op preserves carry, then explicit clear
        load(1, 0, 16'hFFFF);
        load(0, 1, 16'h0001);
        issue(4'd0, 0);
        load(1, 0, 16'h00FF);
        load(0, 1, 16'h0F0F);
        issue(4'd2, 0);
        check("and_keeps_carry", carry_flag, 1'b1);
        pulse_clear();

        // Invalid op, then recovery
        issue(4'd9, 0);
        check("invalid_sticky", op_error, 1'b1);
        issue(4'd3, 0);

        // Busy blocking and bus readback
        load(1, 1, 16'h1357);
        issue(4'd0, 1);
        bus_check();

        // Reset in the middle of CAPTURE
        load(1, 1, 16'h4321);
        out_en = 1; exec = 1; op = 4'd0;
        @(negedge clk);
        exec = 0;
        @(negedge clk);
        check("in_capture_enable", alu_enable, 1'b1);
        #1 reset = 1;
        #1;
        check_reset_values("midop");
        @(negedge clk);
        reset = 0; out_en = 0;
        model_reset();
        repeat (4) @(negedge clk);
        load(1, 0, 16'h0100);
        load(0, 1, 16'h0023);
        issue(4'd0, 0);
        check("after_reset_result", acc, 16'h0123);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: load(1, 0, 16'($urandom));
                1: load(0, 1, 16'($urandom));
                2: load(1, 1, 16'($urandom));
                3: pulse_clear();
                4: bus_check();
                default: ;
            endcase
            issue(4'($urandom_range(0, 10)), $urandom_range(0, 4) == 0);
        end
        bus_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
